// File: rtl/eval_pkg.sv
// Shared constants and state encoding for the per-piece PST accumulators.
// Holds board geometry, table entry width, the mirror mask and helpers.
package eval_pkg;

   localparam int NUM_SQ      = 64;
   localparam int NUM_RANKS   = 8;
   localparam int PST_W       = 6;
   localparam int MIRROR_MASK = 56;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DONE
   } acc_state_e;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rank_pst_sum.sv
// Combinational signed partial sum of one rank: white entries added,
// mirrored black entries subtracted.
// Ports: w_bits_i/b_bits_i occupancy, w_ent_i/b_ent_i entries, sum_o result.
module rank_pst_sum
   import eval_pkg::*;
#(
   parameter int SCORE_W = 13
) (
   input  logic [7:0]                   w_bits_i,
   input  logic [7:0]                   b_bits_i,
   input  logic [7:0][PST_W-1:0]        w_ent_i,
   input  logic [7:0][PST_W-1:0]        b_ent_i,
   output logic signed [SCORE_W-1:0]    sum_o
);

   always_comb begin
      sum_o = '0;
      for (int j = 0; j < 8; j++) begin
         if (w_bits_i[j]) begin
            sum_o = sum_o + SCORE_W'(signed'(w_ent_i[j]));
         end
         if (b_bits_i[j]) begin
            sum_o = sum_o - SCORE_W'(signed'(b_ent_i[j]));
         end
      end
   end

endmodule

// File: rtl/bishop_pst_accum.sv
// Walks latched bishop bitboards one rank per cycle, summing the packed
// bishop PST as white minus black; 10-cycle fixed latency start to done.
// Ports: clk, rst_n, start, bishops_w, bishops_b, map_data in;
//        busy, done, score out.
// Optional macro BISHOP_PAIR_EN adds +/-PAIR_BONUS for a bishop pair.
module bishop_pst_accum
   import eval_pkg::*;
#(
   parameter int SCORE_W    = 13,
   parameter int PAIR_BONUS = 30
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_SQ-1:0]          bishops_w,
   input  logic [NUM_SQ-1:0]          bishops_b,
   input  logic [NUM_SQ*PST_W-1:0]    map_data,
   output logic                       busy,
   output logic                       done,
   output logic signed [SCORE_W-1:0]  score
);

   acc_state_e                 state_q;
   logic [2:0]                 rank_q;
   logic [NUM_SQ-1:0]          bw_q;
   logic [NUM_SQ-1:0]          bb_q;
   logic signed [SCORE_W-1:0]  acc_q;
   logic signed [SCORE_W-1:0]  acc_d;
   logic signed [SCORE_W-1:0]  score_q;
   logic signed [SCORE_W-1:0]  score_d;
   logic                       busy_q;
   logic                       done_q;

   logic [7:0]                 w_bits;
   logic [7:0]                 b_bits;
   logic [7:0][PST_W-1:0]      w_ent;
   logic [7:0][PST_W-1:0]      b_ent;
   logic signed [SCORE_W-1:0]  part;

   // Rank-indexed muxes; black reads the vertically mirrored square.
   always_comb begin
      w_bits = bw_q[{rank_q, 3'b000} +: 8];
      b_bits = bb_q[{rank_q, 3'b000} +: 8];
      w_ent  = '0;
      b_ent  = '0;
      for (int j = 0; j < 8; j++) begin
         logic [5:0] sq;
         sq = {rank_q, 3'(j)};
         w_ent[j] = map_data[int'(sq) * PST_W +: PST_W];
         b_ent[j] = map_data[int'(sq ^ 6'(MIRROR_MASK)) * PST_W +: PST_W];
      end
   end

   rank_pst_sum #(
      .SCORE_W (SCORE_W)
   ) u_rank (
      .w_bits_i (w_bits),
      .b_bits_i (b_bits),
      .w_ent_i  (w_ent),
      .b_ent_i  (b_ent),
      .sum_o    (part)
   );

   assign acc_d = acc_q + part;

`ifdef BISHOP_PAIR_EN
   logic [6:0] cnt_w_q;
   logic [6:0] cnt_b_q;

   always_comb begin
      score_d = acc_q;
      if (cnt_w_q >= 7'd2) begin
         score_d = score_d + SCORE_W'(PAIR_BONUS);
      end
      if (cnt_b_q >= 7'd2) begin
         score_d = score_d - SCORE_W'(PAIR_BONUS);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_w_q <= '0;
         cnt_b_q <= '0;
      end else if (state_q == ST_IDLE && start) begin
         cnt_w_q <= '0;
         cnt_b_q <= '0;
      end else if (state_q == ST_ACCUM) begin
         cnt_w_q <= cnt_w_q + 7'(popcnt8(w_bits));
         cnt_b_q <= cnt_b_q + 7'(popcnt8(b_bits));
      end
   end
`else
   assign score_d = acc_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rank_q  <= '0;
         bw_q    <= '0;
         bb_q    <= '0;
         acc_q   <= '0;
         score_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bw_q    <= bishops_w;
                  bb_q    <= bishops_b;
                  acc_q   <= '0;
                  rank_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               acc_q  <= acc_d;
               rank_q <= rank_q + 3'd1;
               if (rank_q == 3'(NUM_RANKS - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               score_q <= score_d;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign score = score_q;

endmodule

// File: tb/tb_bishop_pst_accum.sv
// Directed bench for bishop_pst_accum: table sums, latency, ignored
// starts, mid-run reset; expectations honour BISHOP_PAIR_EN.
module tb_bishop_pst_accum;
   import eval_pkg::*;

`ifdef BISHOP_PAIR_EN
   localparam int PB = 30;
`else
   localparam int PB = 0;
`endif

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [63:0]        bw;
   logic [63:0]        bb;
   logic [383:0]       map;
   logic               busy;
   logic               done;
   logic signed [12:0] score;

   int checks;
   int failures;

   int pst [64] = '{
      -20, -20, -20, -20, -20, -20, -20, -20,
      -10,   5,   0,   0,   0,   0,   5, -10,
      -10,  10,  10,  10,  10,  10,  10, -10,
      -10,   0,  10,  10,  10,  10,   0, -10,
      -10,   5,   5,  10,  10,   5,   5, -10,
      -10,   0,   5,  10,  10,   5,   0, -10,
      -10,   0,   0,   0,   0,   0,   0, -10,
      -20, -10, -10, -10, -10, -10, -10, -20
   };

   bishop_pst_accum u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bishops_w (bw),
      .bishops_b (bb),
      .map_data  (map),
      .busy      (busy),
      .done      (done),
      .score     (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run(input string tag, input logic [63:0] w,
                      input logic [63:0] b, input int exp,
                      input bit ign);
      int lat;
      int np;
      bw    = w;
      bb    = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bw    = ~w;
      bb    = ~b;
      lat   = -1;
      np    = 0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk);
         #1;
         start = ign && (c == 2 || c == 5);
         if (done) begin
            np++;
            if (lat < 0) lat = c;
         end
      end
      start = 1'b0;
      chk({tag, ":lat"}, lat, 9);
      chk({tag, ":pulses"}, np, 1);
      chk({tag, ":score"}, int'(score), exp);
      chk({tag, ":busy"}, int'(busy), 0);
   endtask

   function automatic logic [63:0] sq(input int a, input int b2);
      logic [63:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b2 >= 0) v[b2] = 1'b1;
      return v;
   endfunction

   initial begin
      int np;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      bw       = '0;
      bb       = '0;
      for (int i = 0; i < 64; i++) begin
         map[i*6 +: 6] = 6'(pst[i]);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst:busy", int'(busy), 0);
      chk("rst:done", int'(done), 0);
      chk("rst:score", int'(score), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run("w27",    sq(27, -1), '0,         10,        1'b0);
      run("b27",    '0,         sq(27, -1), -10,       1'b0);
      run("w2_5",   sq(2, 5),   '0,         -40 + PB,  1'b0);
      run("wall",   '1,         '0,         -200 + PB, 1'b0);
      run("ball",   '0,         '1,         200 - PB,  1'b0);
      run("both",   '1,         '1,         0,         1'b0);
      run("empty",  '0,         '0,         0,         1'b0);
      run("w9b9",   sq(9, -1),  sq(9, -1),  5,         1'b0);
      run("mix",    sq(27, 36), sq(0, -1),  40 + PB,   1'b0);
      run("ignore", sq(27, -1), '0,         10,        1'b1);

      bw    = '1;
      bb    = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst:busy", int'(busy), 0);
      chk("midrst:done", int'(done), 0);
      chk("midrst:score", int'(score), 0);
      @(negedge clk);
      rst_n = 1'b1;
      np = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (done) np++;
      end
      chk("midrst:nodone", np, 0);
      chk("midrst:hold", int'(score), 0);

      run("fresh",  sq(2, 5),   '0,         -40 + PB,  1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bishop_pst_accum.md
Name: bishop_pst_accum

Overview:
- Sequential consumer of the packed bishop piece-square table: 64 signed 6-bit entries, 384 bits, entry i at bits [6i+5:6i].
- On a start pulse, walks the white and black bishop bitboards one rank per cycle and accumulates a signed positional score, white minus black.
- Score goes to the top-level evaluation adder alongside the other per-piece accumulators.

Parameters:
- PST_W, 6, width of one signed table entry.
- SCORE_W, 13, width of the signed score output. Covers the worst case of ±64×20 per side.
- PAIR_BONUS, 30, signed bishop-pair bonus. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- bishops_w  in  64  white bishop bitboard; bit i = square i.
- bishops_b  in  64  black bishop bitboard; bit i = square i, white-relative.
- map_data  in  384  packed table, white-relative, entry i at [6i+5:6i]; static during operation.
- busy  out  1  high while accumulating.
- done  out  1  one-cycle pulse when score is final.
- score  out  SCORE_W  signed result, held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, rank counter=0, accumulator=0.
  - busy=0, done=0, score=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1: latch bishops_w/bishops_b, clear accumulator, rank=0, go to ACCUM.
  - busy rises the cycle after start is sampled.
- ACCUM, one rank r per cycle (r = 0..7):
  - White contribution: for squares s = 8r..8r+7, add sign-extended entry[s] where bishops_w[s]=1.
  - Black contribution: subtract sign-extended entry[s^56] where bishops_b[s]=1 (vertical mirror).
  - Per-rank partial sum is formed combinationally and added to the accumulator.
  - After r=7 is added, go to DONE.
- DONE:
  - score <= accumulator; done=1 for exactly this one cycle; busy=0.
  - Next cycle returns to IDLE.
- Latency: start sampled at edge E0; ranks added at E1..E8; done high during the cycle after E9 with score valid. Fixed 10 cycles start→done, independent of the data.
- start while busy, or in DONE: ignored, no queueing.
- The latched bitboards are used throughout, so input changes after the start edge have no effect.
- Arithmetic:
  - Entries are sign-extended from PST_W to SCORE_W before any addition.
  - No saturation is needed; SCORE_W covers the extremes.
- Reset mid-operation: immediate return to IDLE, outputs as at reset, no done pulse.
- Empty bitboards: score=0 and done still pulses on schedule.

Optional Feature:
- Macro BISHOP_PAIR_EN.
- Defined:
  - Popcounts of the latched bitboards are accumulated per rank alongside the score.
  - In DONE, score gets +PAIR_BONUS if the white count ≥2, and −PAIR_BONUS if the black count ≥2.
  - Latency is unchanged.
- Undefined: no popcount logic; score is the pure table sum.

Decomposition:
- Shared package (eval_pkg) holds:
  - NUM_SQ=64, NUM_RANKS=8, PST_W, the MIRROR_MASK=56 constant.
  - The IDLE/ACCUM/DONE state encoding, shared with the other piece accumulators.
- Sub-module rank_pst_sum: combinational.
  - Inputs: 8 bitboard bits per side, 16 entries, mirrored for black.
  - Output: signed partial sum of the rank.
  - Instantiated once and fed by rank-indexed muxes.

Test Plan:
- White bishop at square 27 only, black empty, start → done at cycle 10 after start, score=+10.
- Black bishop at square 27 only (mirror index 35) → score=−10. White at squares 2 and 5 only → score=−40.
- bishops_w all ones, black empty → score=−200. Black all ones, white empty → +200. Both all ones → 0.
- Start pulses at cycles 3 and 6 after a first accepted start → the later pulses are ignored; exactly one done pulse, with the first result.
- rst_n driven low during rank 4 → busy=0, score=0, no done. A fresh start after release → correct result.
- With BISHOP_PAIR_EN: white at squares 2 and 5, black empty → score=−40+30=−10. One bishop per side at 27 → 0, no bonus.
